// File: rtl/board_writer.sv
// board_writer: write side of the 1k-entry board BMEM scanned by vga_controller.
//
// Buffers cell updates (x, y, data) from game logic in a small FIFO and issues
// at most one BMEM write per cycle at waddr = {y[4:0], x[4:0]}. A clear request
// flushes the FIFO and sweeps CLEAR_VAL over rows 0..ROWS-1.
//
// Optional feature: define BLANKWRITE_EN to allow writes (updates and clear
// sweep) only while i_blank is high. Undefined: i_blank is ignored.
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_clear_req    1-cycle pulse: flush FIFO, then clear the board
//   i_cell_valid   update request valid
//   o_cell_ready   update accepted this cycle if valid
//   i_cell_x       block column 0..31
//   i_cell_y       block row 0..ROWS-1
//   i_cell_data    new cell contents
//   i_blank        high while VGA is outside the visible region
//   o_we           BMEM write enable, one write per high cycle
//   o_waddr        BMEM write address {y, x}
//   o_wdata        BMEM write data
//   o_busy         clear pending or in progress
//   o_oob_err      1-cycle pulse: accepted update had y >= ROWS

module board_writer #(
    parameter int unsigned       DATA_W     = 4,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       ROWS       = 24,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clear_req,
    input  logic              i_cell_valid,
    output logic              o_cell_ready,
    input  logic [4:0]        i_cell_x,
    input  logic [4:0]        i_cell_y,
    input  logic [DATA_W-1:0] i_cell_data,
    input  logic              i_blank,
    output logic              o_we,
    output logic [9:0]        o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_busy,
    output logic              o_oob_err
);

    localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W     = PTR_W + 1;
    localparam int unsigned      ENT_W     = 10 + DATA_W;
    localparam logic [9:0]       LAST_ADDR = 10'(ROWS * 32 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [5:0]       ROWS_LIM  = 6'(ROWS);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StClear
    } state_e;

    // ------------------------------------------------------------------
    // Write gating
    // ------------------------------------------------------------------
    logic w_write_ok;
`ifdef BLANKWRITE_EN
    assign w_write_ok = i_blank;
`else
    logic w_unused_blank;
    assign w_unused_blank = i_blank;
    assign w_write_ok     = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Update FIFO; entry packs {y, x, data} so the address is the top 10 bits
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_ready;
    logic             w_push_hs;
    logic             w_in_range;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_entry;
    logic [ENT_W-1:0] w_head;

    state_e           r_state;
    state_e           w_state_d;

    assign w_full       = (r_count == FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign w_ready      = ~w_full & ~i_clear_req & (r_state != StClear);
    assign o_cell_ready = w_ready;
    assign w_push_hs    = i_cell_valid & w_ready;
    assign w_in_range   = ({1'b0, i_cell_y} < ROWS_LIM);
    // Out-of-range updates complete the handshake but are dropped here.
    assign w_push       = w_push_hs & w_in_range;
    assign w_entry      = {i_cell_y, i_cell_x, i_cell_data};
    assign w_head       = r_fifo[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear_req) begin
            // Flush: anything queued at this point is never written.
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write FSM. StWrite holds the popped entry in r_ent; its BMEM write is
    // registered on the way out of that cycle, so every output is a flop.
    // ------------------------------------------------------------------
    logic [9:0]        r_sweep;
    logic [9:0]        w_sweep_d;
    logic [ENT_W-1:0]  r_ent;
    logic [ENT_W-1:0]  w_ent_d;
    logic              r_we;
    logic              w_we_d;
    logic [9:0]        r_waddr;
    logic [9:0]        w_waddr_d;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_d;
    logic              r_busy;
    logic              w_busy_d;
    logic              r_oob;
    logic              w_oob_d;

    always_comb begin
        w_state_d = r_state;
        w_sweep_d = r_sweep;
        w_ent_d   = r_ent;
        w_pop     = 1'b0;
        w_we_d    = 1'b0;
        w_waddr_d = r_waddr;
        w_wdata_d = r_wdata;

        unique case (r_state)
            StIdle: begin
                if (i_clear_req) begin
                    w_state_d = StClear;
                    w_sweep_d = '0;
                end else if (!w_empty && w_write_ok) begin
                    w_pop     = 1'b1;
                    w_ent_d   = w_head;
                    w_state_d = StWrite;
                end
            end
            StWrite: begin
                // The entry already popped is always written, even if a
                // clear arrives now.
                w_we_d    = 1'b1;
                w_waddr_d = r_ent[ENT_W-1:DATA_W];
                w_wdata_d = r_ent[DATA_W-1:0];
                if (i_clear_req) begin
                    w_state_d = StClear;
                    w_sweep_d = '0;
                end else if (!w_empty && w_write_ok) begin
                    w_pop   = 1'b1;
                    w_ent_d = w_head;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StClear: begin
                if (i_clear_req) begin
                    w_sweep_d = '0;
                end else if (w_write_ok) begin
                    w_we_d    = 1'b1;
                    w_waddr_d = r_sweep;
                    w_wdata_d = CLEAR_VAL;
                    if (r_sweep == LAST_ADDR) begin
                        w_state_d = StIdle;
                        w_sweep_d = '0;
                    end else begin
                        w_sweep_d = r_sweep + 10'd1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // busy stays up through the cycle carrying the final sweep write.
    assign w_busy_d = i_clear_req | (r_state == StClear);
    assign w_oob_d  = w_push_hs & ~w_in_range;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
            r_sweep <= '0;
            r_ent   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_oob   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_sweep <= w_sweep_d;
            r_ent   <= w_ent_d;
            r_we    <= w_we_d;
            r_waddr <= w_waddr_d;
            r_wdata <= w_wdata_d;
            r_busy  <= w_busy_d;
            r_oob   <= w_oob_d;
        end
    end

    assign o_we      = r_we;
    assign o_waddr   = r_waddr;
    assign o_wdata   = r_wdata;
    assign o_busy    = r_busy;
    assign o_oob_err = r_oob;

endmodule
